// File: rtl/pipe_scheduler.sv
// Game-level sequencer for the two-pipe scroller: IDLE/RUN/OVER FSM,
// frame-divided scroll tick, pipe positions, gap patterns and score.
module pipe_scheduler #(
  parameter int SCREEN_W     = 640,
  parameter int PIPE_W       = 60,
  parameter int PIPE_SPACING = 320,
  parameter int STEP         = 2,
  parameter int TICK_DIV     = 4,
  parameter int BIRD_X       = 200,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       FrameStart,
  input  logic       Button,
  input  logic       Collision,
  output logic [9:0] PipesPosition1,
  output logic [9:0] PipesPosition2,
  output logic [2:0] Pattern1,
  output logic [2:0] Pattern2,
  output logic       ScrollTick,
  output logic       Running,
  output logic       GameOver,
  output logic [7:0] Score
);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [10:0] P1_INIT = 11'(SCREEN_W + PIPE_W);
  localparam logic [10:0] P2_INIT =
    11'(SCREEN_W + PIPE_W + PIPE_SPACING);
  localparam logic [10:0] WRAP = 11'(2 * PIPE_SPACING - STEP);
  localparam logic [10:0] STP  = 11'(STEP);
  localparam logic [10:0] BIRD = 11'(BIRD_X);

  state_t state_q, state_d;
  logic [10:0] pos1_q, pos1_d, pos2_q, pos2_d;
  logic [2:0] pat1_q, pat1_d, pat2_q, pat2_d;
  logic [7:0] score_q, score_d;
  logic [DW-1:0] div_q, div_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic btn_q;
  logic tick_q, tick_d;

  logic press;
  logic wrap1, wrap2, pass1, pass2;
  logic [10:0] mv1, mv2;
  logic [8:0] sum;

  assign press = Button & ~btn_q;

  assign wrap1 = pos1_q < STP;
  assign wrap2 = pos2_q < STP;
  assign pass1 = (pos1_q >= BIRD) && ((pos1_q - STP) < BIRD);
  assign pass2 = (pos2_q >= BIRD) && ((pos2_q - STP) < BIRD);
  assign mv1 = wrap1 ? pos1_q + WRAP : pos1_q - STP;
  assign mv2 = wrap2 ? pos2_q + WRAP : pos2_q - STP;
  assign sum = {1'b0, score_q} + {8'd0, pass1} + {8'd0, pass2};

  always_comb begin
    state_d = state_q;
    pos1_d  = pos1_q;
    pos2_d  = pos2_q;
    pat1_d  = pat1_q;
    pat2_d  = pat2_q;
    score_d = score_q;
    div_d   = div_q;
    tick_d  = 1'b0;
    // Galois form, taps 16,14,13,11; free-running in every state
    lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0);
    unique case (state_q)
      IDLE: begin
        pos1_d  = P1_INIT;
        pos2_d  = P2_INIT;
        score_d = '0;
        div_d   = '0;
        if (press) begin
          pat1_d  = lfsr_q[2:0];
          pat2_d  = lfsr_q[5:3];
          state_d = RUN;
        end
      end
      RUN: begin
        if (Collision) begin
          state_d = OVER;
        end else if (FrameStart) begin
          if (div_q == DIV_LAST) begin
            div_d  = '0;
            tick_d = 1'b1;
            pos1_d = mv1;
            pos2_d = mv2;
            if (wrap1) pat1_d = lfsr_q[2:0];
            if (wrap2) pat2_d = lfsr_q[5:3];
            score_d = sum[8] ? 8'hFF : sum[7:0];
          end else begin
            div_d = div_q + DW'(1);
          end
        end
      end
      OVER: begin
        if (press) begin
          state_d = IDLE;
          pos1_d  = P1_INIT;
          pos2_d  = P2_INIT;
          score_d = '0;
          div_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pos1_q  <= P1_INIT;
      pos2_q  <= P2_INIT;
      pat1_q  <= '0;
      pat2_q  <= '0;
      score_q <= '0;
      div_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      btn_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos1_q  <= pos1_d;
      pos2_q  <= pos2_d;
      pat1_q  <= pat1_d;
      pat2_q  <= pat2_d;
      score_q <= score_d;
      div_q   <= div_d;
      lfsr_q  <= lfsr_d;
      btn_q   <= Button;
      tick_q  <= tick_d;
    end
  end

  assign PipesPosition1 = pos1_q[9:0];
  assign PipesPosition2 = pos2_q[9:0];
  assign Pattern1       = pat1_q;
  assign Pattern2       = pat2_q;
  assign ScrollTick     = tick_q;
  assign Running        = (state_q == RUN);
  assign GameOver       = (state_q == OVER);
  assign Score          = score_q;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Bench for pipe_scheduler: checkpoint table plus a tick scoreboard,
// and a fast-scrolling second instance for score saturation.
module tb_pipe_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fs = 1'b0, btn = 1'b0, col = 1'b0;
  logic [9:0] p1, p2;
  logic [2:0] pat1, pat2;
  logic tick, run, over;
  logic [7:0] score;

  logic fs2 = 1'b0, btn2 = 1'b0, col2 = 1'b0;
  logic [9:0] q_p1, q_p2;
  logic [2:0] q_pat1, q_pat2;
  logic q_tick, q_run, q_over;
  logic [7:0] q_score;

  pipe_scheduler dut (
    .Clk(clk), .Reset(rst), .FrameStart(fs), .Button(btn),
    .Collision(col), .PipesPosition1(p1), .PipesPosition2(p2),
    .Pattern1(pat1), .Pattern2(pat2), .ScrollTick(tick),
    .Running(run), .GameOver(over), .Score(score)
  );

  pipe_scheduler #(.STEP(80), .TICK_DIV(1)) sat (
    .Clk(clk), .Reset(rst), .FrameStart(fs2), .Button(btn2),
    .Collision(col2), .PipesPosition1(q_p1),
    .PipesPosition2(q_p2), .Pattern1(q_pat1), .Pattern2(q_pat2),
    .ScrollTick(q_tick), .Running(q_run), .GameOver(q_over),
    .Score(q_score)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act,
                       input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else m_lfsr <= {1'b0, m_lfsr[15:1]} ^
                   (m_lfsr[0] ? 16'hB400 : 16'h0);
  end

  typedef struct {
    int p1; int p2; int sc; int pat1; int pat2;
  } exp_t;
  exp_t sb[$];

  int m_p1, m_p2, m_sc, m_pat1, m_pat2, m_div, m_ticks;
  int m_state;

  task automatic mv(input int p, input int step, output int np,
                    output int ps, output bit wr);
    wr = p < step;
    ps = (p >= 200 && p - step < 200) ? 1 : 0;
    np = wr ? p + 640 - step : p - step;
  endtask

  task automatic model_reset();
    m_p1 = 700; m_p2 = 1020; m_sc = 0;
    m_div = 0; m_ticks = 0;
  endtask

  task automatic model_tick();
    int n1, n2, s1, s2;
    bit w1, w2;
    exp_t e;
    mv(m_p1, 2, n1, s1, w1);
    mv(m_p2, 2, n2, s2, w2);
    if (w1) m_pat1 = int'(m_lfsr[2:0]);
    if (w2) m_pat2 = int'(m_lfsr[5:3]);
    m_p1 = n1; m_p2 = n2;
    m_sc = m_sc + s1 + s2;
    if (m_sc > 255) m_sc = 255;
    m_ticks++;
    e.p1 = m_p1; e.p2 = m_p2; e.sc = m_sc;
    e.pat1 = m_pat1; e.pat2 = m_pat2;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (tick) begin
      if (sb.size() == 0) begin
        check("unexpected_tick", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_pos1", int'(p1), e.p1);
        check("sb_pos2", int'(p2), e.p2);
        check("sb_score", int'(score), e.sc);
        check("sb_pat1", int'(pat1), e.pat1);
        check("sb_pat2", int'(pat2), e.pat2);
      end
    end
  end

  // one FrameStart pulse followed by one quiet cycle
  task automatic frame();
    fs = 1'b1;
    if (m_state == 1) begin
      if (m_div == 3) begin
        model_tick();
        m_div = 0;
      end else begin
        m_div++;
      end
    end
    @(negedge clk);
    fs = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_to(input int t);
    while (m_ticks < t) frame();
  endtask

  task automatic press_start();
    btn = 1'b1;
    m_pat1 = int'(m_lfsr[2:0]);
    m_pat2 = int'(m_lfsr[5:3]);
    m_state = 1;
    @(negedge clk);
    check("press_running", int'(run), 1);
    check("press_pat1", int'(pat1), m_pat1);
    check("press_pat2", int'(pat2), m_pat2);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pos1"}, int'(p1), 700);
    check({tag, "_pos2"}, int'(p2), 1020);
    check({tag, "_score"}, int'(score), 0);
    check({tag, "_running"}, int'(run), 0);
    check({tag, "_gameover"}, int'(over), 0);
    check({tag, "_tick"}, int'(tick), 0);
  endtask

  typedef struct { int t; int p1; int p2; int sc; } row_t;
  row_t rows[5];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rows[0] = '{1, 698, 1018, 0};
    rows[1] = '{250, 200, 520, 0};
    rows[2] = '{251, 198, 518, 1};
    rows[3] = '{350, 0, 320, 1};
    rows[4] = '{351, 638, 318, 1};
    m_state = 0; m_pat1 = 0; m_pat2 = 0;
    model_reset();

    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    check("rst_pat1", int'(pat1), 0);
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("idle");

    col = 1'b1;
    repeat (4) frame();
    col = 1'b0;
    check("idle_col_gameover", int'(over), 0);
    check("idle_col_running", int'(run), 0);
    check("idle_pos1", int'(p1), 700);

    press_start();
    repeat (9) @(negedge clk);
    btn = 1'b0;
    check("held_running", int'(run), 1);

    for (int i = 0; i < 5; i++) begin
      run_to(rows[i].t);
      check("row_pos1", int'(p1), rows[i].p1);
      check("row_pos2", int'(p2), rows[i].p2);
      check("row_score", int'(score), rows[i].sc);
      if (i == 0) begin
        repeat (3) frame();
        check("notick_pos1", int'(p1), 698);
        check("notick_pos2", int'(p2), 1018);
      end
      if (i == 4) check("wrap_pat1", int'(pat1), m_pat1);
    end

    while (m_div != 3) frame();
    fs = 1'b1; col = 1'b1; m_state = 2;
    @(negedge clk);
    fs = 1'b0; col = 1'b0;
    check("col_tick", int'(tick), 0);
    check("col_gameover", int'(over), 1);
    check("col_running", int'(run), 0);
    check("col_pos1", int'(p1), m_p1);
    check("col_pos2", int'(p2), m_p2);
    col = 1'b1;
    repeat (8) frame();
    col = 1'b0;
    check("over_pos1", int'(p1), m_p1);
    check("over_score", int'(score), m_sc);
    check("over_gameover", int'(over), 1);

    btn = 1'b1; m_state = 0; model_reset();
    @(negedge clk);
    check_reset_vals("reidle");
    repeat (5) @(negedge clk);
    check("held_over_running", int'(run), 0);
    btn = 1'b0;
    @(negedge clk);

    press_start();
    btn = 1'b0;
    run_to(5);
    check("rerun_pos1", int'(p1), 690);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    check("midrst_pat2", int'(pat2), 0);
    rst = 1'b0;
    m_state = 0; model_reset(); sb.delete();
    @(negedge clk);
    press_start();
    btn = 1'b0;
    check("sb_empty", sb.size(), 0);

    begin
      int s1p, s2p, sc, n1, n2, a, b;
      bit w;
      s1p = 700; s2p = 1020; sc = 0;
      btn2 = 1'b1;
      @(negedge clk);
      btn2 = 1'b0;
      check("sat_running", int'(q_run), 1);
      for (int k = 0; k < 1100; k++) begin
        fs2 = 1'b1;
        mv(s1p, 80, n1, a, w);
        mv(s2p, 80, n2, b, w);
        s1p = n1; s2p = n2;
        sc = sc + a + b;
        if (sc > 255) sc = 255;
        @(negedge clk);
        check("sat_pos1", int'(q_p1), s1p);
        check("sat_pos2", int'(q_p2), s2p);
        check("sat_score", int'(q_score), sc);
      end
      fs2 = 1'b0;
      check("sat_final", int'(q_score), 255);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_scheduler.md
Name: pipe_scheduler

Overview:
- Game-level sequencer for the two-pipe scrolling datapath.
- Owns the IDLE/RUN/OVER game state machine and the frame-divided scroll tick.
- Owns both pipe X positions (with wrap-around), the per-pipe gap pattern from an LFSR, and the score counter.
- Feeds the pipe drawing units and the pattern logic. Consumes a collision flag from the status checker and the player button.

Parameters:
- SCREEN_W, 640: visible width in pixels.
- PIPE_W, 60: pipe width in pixels.
- PIPE_SPACING, 320: distance between pipe right edges. Period of the two-pipe pattern is 2*PIPE_SPACING.
- STEP, 2: pixels moved per scroll tick. Must be ≥1.
- TICK_DIV, 4: FrameStart pulses per scroll tick. Must be ≥1.
- BIRD_X, 200: bird X column used for scoring.
- LFSR_SEED, 16'hACE1: LFSR reset value. Must be nonzero.
- Constraint: SCREEN_W+PIPE_W+PIPE_SPACING ≤ 1023.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- FrameStart  in  1  one-cycle pulse per video frame.
- Button  in  1  debounced player button, level.
- Collision  in  1  bird/pipe overlap flag, level.
- PipesPosition1  out  10  pipe 1 right-edge X. Pipe occupies [pos-PIPE_W, pos).
- PipesPosition2  out  10  pipe 2 right-edge X.
- Pattern1  out  3  pipe 1 gap index.
- Pattern2  out  3  pipe 2 gap index.
- ScrollTick  out  1  one-cycle pulse on each scroll step.
- Running  out  1  high in RUN.
- GameOver  out  1  high in OVER.
- Score  out  8  pipes passed, saturating.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high; all state updates on the rising edge of Clk.
- Reset values:
  - state=IDLE; PipesPosition1=P1_INIT=SCREEN_W+PIPE_W (700); PipesPosition2=P2_INIT=P1_INIT+PIPE_SPACING (1020).
  - Pattern1=0, Pattern2=0, Score=0, ScrollTick=0, Running=0, GameOver=0.
  - Frame divider=0; LFSR=LFSR_SEED; button history register=0.
- Press detect: press = Button & ~Button_q, where Button_q is the 1-cycle delayed Button. A held button gives exactly one press.
- LFSR: 16-bit Galois, taps 16,14,13,11. Advances every cycle in every state, and never reaches zero.
- FSM:
  - IDLE: positions held at their INIT values; Score=0; divider=0. On press: load Pattern1=lfsr[2:0], Pattern2=lfsr[5:3]; go to RUN next cycle.
  - RUN: Running=1. On Collision=1, go to OVER next cycle. Collision has priority over any same-cycle tick: no movement, no score change, ScrollTick=0 that cycle.
  - OVER: GameOver=1; positions, patterns and Score frozen. On press, go to IDLE. IDLE entry reloads the INIT positions and clears Score and the divider. Collision is ignored outside RUN.
- Divider (RUN only): counts FrameStart pulses. On a FrameStart with divider==TICK_DIV-1, the divider goes to 0 and a tick occurs in that cycle.
- On a tick: ScrollTick=1 for that single cycle, registered (outputs update on the same edge as the positions). Each pipe independently:
  - If pos < STEP: pos ← pos+2*PIPE_SPACING-STEP (wrap, spacing preserved) and PatternN ← a fresh LFSR slice (pipe 1 lfsr[2:0], pipe 2 lfsr[5:3]).
  - Otherwise: pos ← pos-STEP.
  - If pos ≥ BIRD_X and pos-STEP < BIRD_X, Score increments, saturating at 255.
  - If both pipes score in the same tick, add 2, still saturating.
- Latency: press to Running=1 is 1 cycle. Collision to GameOver=1 is 1 cycle. FrameStart (terminal count) to position update is 1 cycle.
- Arithmetic: all position math is unsigned 11-bit internally, truncated to 10 bits on output.
- Reset mid-RUN: returns to IDLE on the next edge with all reset values; the LFSR is reseeded.

Test Plan:
- Reset asserted 3 cycles, then deasserted → PipesPosition1=700, PipesPosition2=1020, Score=0, Running=0, GameOver=0, ScrollTick=0.
- Button rises in IDLE and is held 10 cycles → Running=1 one cycle after the rise; only one press registered. Then 4 FrameStart pulses → exactly one ScrollTick, after which pos1=698 and pos2=1018. Three further pulses → no tick.
- 350 ticks → pos1=0. Next tick → pos1=638, pos2=318 (spacing 320 kept); Pattern1 takes the LFSR slice.
- Ticks from start: the Score 0→1 transition occurs exactly on the tick moving pos1 from 200 to 198 (tick 251), and not on 202→200.
- Collision=1 in the same cycle as a terminal-count FrameStart → no ScrollTick; positions unchanged; GameOver=1 next cycle. Further FrameStart pulses → frozen. Press → IDLE with positions 700/1020, Score=0.
- Score preloaded near saturation (force) with a dual-pass tick → Score=255. Reset asserted during RUN → all reset values next cycle.
